// File: rtl/seg7_scan_reader.sv
// seg7_scan_reader
//   Watches a time-multiplexed seven-segment bus, accepts a digit pattern
//   only after it has been stable for STABLE consecutive samples, decodes it
//   back to BCD and emits one record per change of a digit's value.
//
// Ports
//   clk, rst    : clock, synchronous active-high reset
//   seg[6:0]    : segment lines a..g (seg[6]=a ... seg[0]=g), active-high
//   dig_en      : one-hot digit strobes (NDIG bits)
//   out_ready   : consumer accepts the current record
//   out_valid   : record available; data holds until out_ready
//   out_digit   : index of the strobe that was high
//   out_bcd     : 0-9, 4'hA blank, 4'hE invalid pattern
//   out_err     : out_bcd == 4'hE
//   ovf         : sticky, a capture was dropped while the slot was busy
module seg7_scan_reader #(
    parameter int NDIG   = 4,
    parameter int STABLE = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [6:0]               seg,
    input  logic [NDIG-1:0]          dig_en,
    input  logic                     out_ready,
    output logic                     out_valid,
    output logic [$clog2(NDIG)-1:0]  out_digit,
    output logic [3:0]               out_bcd,
    output logic                     out_err,
    output logic                     ovf
);
    localparam int DW = $clog2(NDIG);
    localparam int SW = NDIG + 7;

    function automatic logic [3:0] decode(input logic [6:0] s);
        logic [3:0] c;
        case (s)
            7'h7E:   c = 4'd0;
            7'h30:   c = 4'd1;
            7'h6D:   c = 4'd2;
            7'h79:   c = 4'd3;
            7'h33:   c = 4'd4;
            7'h5B:   c = 4'd5;
            7'h5F:   c = 4'd6;
            7'h70:   c = 4'd7;
            7'h7F:   c = 4'd8;
            7'h7B:   c = 4'd9;
            7'h00:   c = 4'hA;
            default: c = 4'hE;
        endcase
        return c;
    endfunction

    logic [SW-1:0]         sample, prev_q, prev_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [NDIG-1:0][3:0]  last_q, last_d;
    logic                  out_valid_q, out_valid_d;
    logic [DW-1:0]         out_digit_q, out_digit_d;
    logic [3:0]            out_bcd_q, out_bcd_d;
    logic                  out_err_q, out_err_d;
    logic                  ovf_q, ovf_d;

    logic                  onehot, same, capture, is_new, slot_free, emit, drop;
    logic [DW-1:0]         idx;
    logic [3:0]            code;

    // The run counter is the whole scan FSM: 0 = IDLE, 1..STABLE-1 = TRACK,
    // STABLE = HOLD (window already consumed).
    always_comb begin
        sample = {dig_en, seg};
        prev_d = sample;
        onehot = (dig_en != '0) && ((dig_en & (dig_en - NDIG'(1))) == '0);
        same   = (sample == prev_q);

        idx = '0;
        for (int i = 0; i < NDIG; i++) begin
            if (dig_en[i]) idx = DW'(i);
        end
        code = decode(seg);

        if (!onehot)
            cnt_d = '0;
        else if (same)
            cnt_d = (cnt_q == 4'(STABLE)) ? cnt_q : cnt_q + 4'd1;
        else
            cnt_d = 4'd1;

        capture   = onehot && same && (cnt_q == 4'(STABLE - 1));
        is_new    = (code != last_q[idx]);
        slot_free = !out_valid_q || out_ready;
        emit      = capture && is_new && slot_free;
        // A dropped capture leaves last[] alone so the next window retries.
        drop      = capture && is_new && !slot_free;

        out_valid_d = out_valid_q && !out_ready;
        out_digit_d = out_digit_q;
        out_bcd_d   = out_bcd_q;
        out_err_d   = out_err_q;
        ovf_d       = ovf_q | drop;
        last_d      = last_q;
        if (emit) begin
            out_valid_d = 1'b1;
            out_digit_d = idx;
            out_bcd_d   = code;
            out_err_d   = (code == 4'hE);
            last_d[idx] = code;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            prev_q      <= '0;
            cnt_q       <= '0;
            last_q      <= {NDIG{4'hF}};
            out_valid_q <= 1'b0;
            out_digit_q <= '0;
            out_bcd_q   <= '0;
            out_err_q   <= 1'b0;
            ovf_q       <= 1'b0;
        end else begin
            prev_q      <= prev_d;
            cnt_q       <= cnt_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_digit_q <= out_digit_d;
            out_bcd_q   <= out_bcd_d;
            out_err_q   <= out_err_d;
            ovf_q       <= ovf_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_digit = out_digit_q;
    assign out_bcd   = out_bcd_q;
    assign out_err   = out_err_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_seg7_scan_reader.sv
module tb_seg7_scan_reader;
    localparam int NDIG   = 4;
    localparam int STABLE = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [6:0]      seg;
    logic [NDIG-1:0] dig_en;
    logic            out_ready;
    logic            out_valid;
    logic [1:0]      out_digit;
    logic [3:0]      out_bcd;
    logic            out_err;
    logic            ovf;

    always #5 clk = ~clk;

    seg7_scan_reader #(.NDIG(NDIG), .STABLE(STABLE)) dut (
        .clk(clk), .rst(rst), .seg(seg), .dig_en(dig_en),
        .out_ready(out_ready), .out_valid(out_valid), .out_digit(out_digit),
        .out_bcd(out_bcd), .out_err(out_err), .ovf(ovf)
    );

    int errors = 0;
    int checks = 0;

    logic [6:0] pats [10] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33,
                              7'h5B, 7'h5F, 7'h70, 7'h7F, 7'h7B};

    // ---------------- reference model ----------------
    // Keeps the last STABLE samples; a capture happens when the current
    // sample plus the STABLE-1 before it are one identical one-hot sample
    // and the sample before that window was different.
    logic [NDIG+6:0] hist [$];
    logic       m_valid, m_err, m_ovf;
    logic [1:0] m_digit;
    logic [3:0] m_bcd;
    logic [3:0] m_last [NDIG];

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        if (s == 7'h00) return 4'hA;
        for (int i = 0; i < 10; i++) if (pats[i] == s) return 4'(i);
        return 4'hE;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < STABLE; i++) hist.push_back('0);
        m_valid = 0; m_err = 0; m_ovf = 0; m_digit = 0; m_bcd = 0;
        for (int i = 0; i < NDIG; i++) m_last[i] = 4'hF;
    endtask

    task automatic model_edge();
        logic [NDIG+6:0] s;
        logic cap, free;
        int d;
        logic [3:0] c;
        if (rst) begin
            model_reset();
            return;
        end
        s   = {dig_en, seg};
        cap = ($countones(dig_en) == 1);
        for (int k = 1; k < STABLE; k++)
            if (hist[hist.size() - k] != s) cap = 0;
        if (hist[hist.size() - STABLE] == s) cap = 0;
        free = !m_valid || out_ready;
        if (m_valid && out_ready) m_valid = 0;
        if (cap) begin
            d = 0;
            for (int i = 0; i < NDIG; i++) if (dig_en[i]) d = i;
            c = ref_decode(seg);
            if (c != m_last[d]) begin
                if (free) begin
                    m_valid = 1; m_digit = 2'(d); m_bcd = c; m_err = (c == 4'hE);
                    m_last[d] = c;
                end else begin
                    m_ovf = 1;
                end
            end
        end
        hist.push_back(s);
        void'(hist.pop_front());
    endtask

    // One clock: drive inputs, advance model, sample DUT 1 ns after the edge.
    task automatic cyc(input logic r, input logic [3:0] d, input logic [6:0] s,
                       input logic rdy);
        rst = r; dig_en = d; seg = s; out_ready = rdy;
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input int n);
        checks++;
        if (out_valid !== m_valid || ovf !== m_ovf ||
            (m_valid && (out_digit !== m_digit || out_bcd !== m_bcd ||
                         out_err !== m_err))) begin
            errors++;
            $display("FAIL rand cycle %0d got v=%0b d=%0d bcd=%h e=%0b ovf=%0b want v=%0b d=%0d bcd=%h e=%0b ovf=%0b",
                     n, out_valid, out_digit, out_bcd, out_err, ovf,
                     m_valid, m_digit, m_bcd, m_err, m_ovf);
        end
    endtask

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       r;
        logic [3:0] d;
        logic [6:0] s;
        logic       rdy;
        int         n;
        logic       v;
        logic [1:0] dg;
        logic [3:0] bcd;
        logic       er;
        logic       ov;
    } vec_t;

    vec_t tbl [$];

    initial begin
        int recs, bad;
        rst = 1; dig_en = '0; seg = '0; out_ready = 1;
        model_reset();

        //             r  dig      seg    rdy n   v  dg  bcd  er ov
        tbl.push_back('{1, 4'b0000, 7'h00, 1, 2,  0, 0, 4'h0, 0, 0}); // reset
        tbl.push_back('{0, 4'b0001, 7'h6D, 1, 2,  0, 0, 4'h0, 0, 0}); // too short
        tbl.push_back('{0, 4'b0001, 7'h6D, 1, 1,  1, 0, 4'h2, 0, 0}); // t+3
        tbl.push_back('{0, 4'b0001, 7'h6D, 1, 1,  0, 0, 4'h0, 0, 0}); // one cycle only
        tbl.push_back('{0, 4'b0010, 7'h00, 1, 3,  1, 1, 4'hA, 0, 0}); // blank
        tbl.push_back('{0, 4'b0010, 7'h01, 1, 3,  1, 1, 4'hE, 1, 0}); // invalid
        tbl.push_back('{0, 4'b0010, 7'h7F, 1, 2,  0, 0, 4'h0, 0, 0}); // glitch
        tbl.push_back('{0, 4'b0010, 7'h01, 1, 3,  0, 0, 4'h0, 0, 0}); // same code
        tbl.push_back('{0, 4'b0011, 7'h7F, 1, 10, 0, 0, 4'h0, 0, 0}); // multi-hot
        tbl.push_back('{0, 4'b0100, 7'h30, 0, 3,  1, 2, 4'h1, 0, 0}); // held
        tbl.push_back('{0, 4'b1000, 7'h79, 0, 3,  1, 2, 4'h1, 0, 1}); // dropped
        tbl.push_back('{0, 4'b1000, 7'h79, 1, 1,  0, 0, 4'h0, 0, 1}); // retire
        tbl.push_back('{0, 4'b0100, 7'h30, 1, 3,  0, 0, 4'h0, 0, 1}); // repeat
        tbl.push_back('{0, 4'b1000, 7'h79, 1, 3,  1, 3, 4'h3, 0, 1}); // retry
        tbl.push_back('{0, 4'b0001, 7'h5B, 0, 2,  1, 3, 4'h3, 0, 1}); // hold old
        tbl.push_back('{0, 4'b0001, 7'h5B, 1, 1,  1, 0, 4'h5, 0, 1}); // swap
        tbl.push_back('{1, 4'b0001, 7'h5B, 1, 1,  0, 0, 4'h0, 0, 0}); // reset
        tbl.push_back('{0, 4'b0001, 7'h6D, 1, 2,  0, 0, 4'h0, 0, 0});
        tbl.push_back('{1, 4'b0001, 7'h6D, 1, 1,  0, 0, 4'h0, 0, 0}); // rst on capture
        tbl.push_back('{0, 4'b0001, 7'h6D, 1, 3,  1, 0, 4'h2, 0, 0}); // new run
        tbl.push_back('{1, 4'b0001, 7'h6D, 1, 1,  0, 0, 4'h0, 0, 0});
        tbl.push_back('{0, 4'b0001, 7'h6D, 1, 3,  1, 0, 4'h2, 0, 0}); // last[] reset

        for (int i = 0; i < tbl.size(); i++) begin
            for (int k = 0; k < tbl[i].n; k++)
                cyc(tbl[i].r, tbl[i].d, tbl[i].s, tbl[i].rdy);
            checks++;
            if (out_valid !== tbl[i].v || ovf !== tbl[i].ov ||
                ((tbl[i].v || tbl[i].r) &&
                 (out_digit !== tbl[i].dg || out_bcd !== tbl[i].bcd ||
                  out_err !== tbl[i].er))) begin
                errors++;
                $display("FAIL vec%0d got v=%0b d=%0d bcd=%h e=%0b ovf=%0b want v=%0b d=%0d bcd=%h e=%0b ovf=%0b",
                         i, out_valid, out_digit, out_bcd, out_err, ovf,
                         tbl[i].v, tbl[i].dg, tbl[i].bcd, tbl[i].er, tbl[i].ov);
            end
        end

        // ---- scan two rounds of 1,2,3,4 ----
        cyc(1, 4'b0000, 7'h00, 1);
        for (int r = 0; r < 2; r++) begin
            recs = 0; bad = 0;
            for (int dg = 0; dg < 4; dg++) begin
                for (int k = 0; k < 4; k++) begin
                    cyc(0, 4'(1 << dg), pats[dg + 1], 1);
                    if (out_valid) begin
                        recs++;
                        if (out_digit !== 2'(dg) || out_bcd !== 4'(dg + 1)) bad++;
                    end
                end
            end
            checks++;
            if (recs != (r == 0 ? 4 : 0) || bad != 0) begin
                errors++;
                $display("FAIL scan round%0d got records=%0d bad=%0d want records=%0d bad=0",
                         r, recs, bad, (r == 0 ? 4 : 0));
            end
        end
        recs = 0; bad = 0;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 4'b0100, 7'h70, 1);
            if (out_valid) begin
                recs++;
                if (out_digit !== 2'd2 || out_bcd !== 4'd7 || out_err !== 1'b0) bad++;
            end
        end
        checks++;
        if (recs != 1 || bad != 0) begin
            errors++;
            $display("FAIL scan change got records=%0d bad=%0d want records=1 bad=0",
                     recs, bad);
        end

        // ---- randomized against the model ----
        cyc(1, 4'b0000, 7'h00, 1);
        chk_model(0);
        for (int it = 0, n = 1; it < 1200; it++) begin
            logic [3:0] d;
            logic [6:0] s;
            int hold, pick;
            hold = $urandom_range(1, 6);
            if ($urandom_range(0, 99) < 85) d = 4'(1 << $urandom_range(0, 3));
            else                            d = 4'($urandom_range(0, 15));
            pick = $urandom_range(0, 99);
            if (pick < 70)      s = pats[$urandom_range(0, 9)];
            else if (pick < 85) s = 7'h00;
            else                s = 7'($urandom_range(0, 127));
            for (int k = 0; k < hold; k++) begin
                cyc(($urandom_range(0, 299) == 0), d, s,
                    ($urandom_range(0, 3) != 0));
                chk_model(n);
                n++;
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_scan_reader.md
# seg7_scan_reader

Receive-side counterpart to the team's BCD-to-seven-segment driver. Samples a time-multiplexed seven-segment bus (segment lines plus one-hot digit strobes) and requires each pattern to be stable before accepting it. Decodes each accepted pattern back to BCD and emits one record per digit value change on a valid/ready stream. Used as a display-scan monitor and as a loopback checker for segment drivers.

## Interface
- NDIG, default 4: number of multiplexed digits (2..8).
- STABLE, default 3: consecutive identical samples required before a capture (2..15).
- clk  in  1: clock; all logic on rising edge.
- rst  in  1: synchronous, active-high reset.
- seg  in  7: segment lines, active-high; seg[6]=a, seg[5]=b, seg[4]=c, seg[3]=d, seg[2]=e, seg[1]=f, seg[0]=g.
- dig_en  in  NDIG: digit strobes; exactly one bit high selects the digit being driven.
- out_ready  in  1: consumer accepts the record this cycle.
- out_valid  out  1: record available.
- out_digit  out  clog2(NDIG): index of the strobe bit that was high.
- out_bcd  out  4: 0-9 decoded digit; 4'hA blank; 4'hE invalid pattern.
- out_err  out  1: equals (out_bcd == 4'hE); qualified by out_valid.
- ovf  out  1: sticky; a capture was dropped because the output slot was busy.

## Operation
- Decode table (seg hex):
  - 0=7E, 1=30, 2=6D, 3=79, 4=33.
  - 5=5B, 6=5F, 7=70, 8=7F, 9=7B.
  - 00 maps to blank (A). Any other value maps to invalid (E).
- Sample register prev <= {dig_en, seg} every cycle.
- Run counter cnt (4 bits):
  - On each edge: if dig_en is not one-hot, cnt <= 0.
  - Else if {dig_en, seg} == prev, cnt <= sat(cnt+1, STABLE).
  - Else cnt <= 1.
- States:
  - IDLE: cnt == 0.
  - TRACK: 0 < cnt < STABLE.
  - HOLD: cnt == STABLE; the window has been consumed and no further capture occurs in it.
- Transitions:
  - IDLE→TRACK on a one-hot strobe.
  - TRACK→HOLD on the capture edge.
  - Any state→TRACK (cnt=1) on a changed one-hot sample.
  - Any state→IDLE on a non-one-hot strobe.
- Capture event: occurs on the edge where cnt goes STABLE-1 → STABLE.
- Per-digit memory last[i] (4 bits, reset 4'hF = none): a capture whose decoded code equals last[i] is discarded silently.
- Otherwise the capture is emitted:
  - If the slot is free (out_valid=0, or out_valid & out_ready this cycle): load out_digit, out_bcd and out_err, set out_valid, and set last[i] <= code.
  - If the slot is busy: drop the record, set ovf, and leave last[i] unchanged, so a later stable window of that digit retries.
- out_valid handshake:
  - Once high, out_valid and its data hold until out_ready is sampled high.
  - out_ready high with out_valid low has no effect.
- Simultaneous capture and out_ready on a full slot: the old record retires and the new record loads on the same edge. No bubble, no ovf.
- Reset values:
  - out_valid=0, out_digit=0, out_bcd=0, out_err=0, ovf=0.
  - cnt=0 (IDLE), prev=0, all last[i]=4'hF.

## Timing
- A pattern first present in cycle t and held through cycle t+STABLE-1 gives out_valid=1 in cycle t+STABLE. Latency is STABLE cycles from first appearance.
- A pattern held fewer than STABLE cycles produces nothing.
- Holding a pattern longer than STABLE cycles produces exactly one capture attempt.
- Throughput: at most one record per STABLE cycles. A consumer with out_ready tied high never sees ovf.
- Reset asserted mid-run: on the reset edge, all state returns to reset values and any pending record is lost. The first cycle after reset release counts as cycle t of a new run.
- dig_en=0 or multi-hot for one cycle breaks the run; counting restarts at cnt=1 on the next one-hot sample.

## Test plan
- NDIG=4, STABLE=3, out_ready=1. Drive dig_en=0001, seg=6D for 3 cycles → out_valid for 1 cycle at t+3 with out_digit=0, out_bcd=2, out_err=0.
- Scan digits 0..3 with values 1,2,3,4, 4 cycles each, for two full rounds → exactly 4 records in round 1 and none in round 2. Change digit 2 to 7 (seg=70) → one record, digit 2, bcd 7.
- Drive seg=00 on digit 1 → bcd=A, err=0. Then seg=01 → bcd=E, err=1. A 2-cycle glitch of seg=7F → no record.
- out_ready=0 and two distinct stable captures → first record held unchanged, second dropped, ovf=1. Raise out_ready → first retires. That digit's next stable window re-emits the dropped value.
- Multi-hot dig_en=0011 held for 10 cycles → no record, cnt stays 0. Assert rst on the capture cycle → out_valid=0, ovf=0. Replaying the same pattern after reset re-emits it, since last[] was reset to 4'hF.
